// File: rtl/uart_cmd_regfile_if.sv
// Byte stream between uart_rx/uart_tx and the command decoder.
// The master side feeds received bytes and transmitter status; the slave side is the decoder.
interface uart_cmd_regfile_if;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
  logic       uart_tx_done;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;

  modport master (
    output uart_rx_valid, uart_rx_data, uart_rx_break, uart_tx_done,
    input  uart_tx_en, uart_tx_data
  );

  modport slave (
    input  uart_rx_valid, uart_rx_data, uart_rx_break, uart_tx_done,
    output uart_tx_en, uart_tx_data
  );
endinterface

// File: rtl/uart_cmd_regfile.sv
// UART byte-command decoder: 'W' A D writes a register, 'R' A reads one back.
// Every command gets exactly one reply byte; register 0 drives the LEDs.
module uart_cmd_regfile #(
  parameter int          ADDR_BITS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  LED_RESET      = 8'hF0
) (
  input  logic                          clk,
  input  logic                          resetn,
  uart_cmd_regfile_if.slave             bus,
  output logic [7:0]                    led,
  output logic [8*(2**ADDR_BITS)-1:0]   reg_bus,
  output logic                          overrun
);
  localparam int NREG = 2**ADDR_BITS;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] GET_ADDR  = 3'd1;
  localparam logic [2:0] GET_DATA  = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] WAIT_BUSY = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [2:0]           state;
  logic                 op_w;
  logic [ADDR_BITS-1:0] addr;
  logic [31:0]          tmo_cnt;
  logic [7:0]           regs [NREG];

  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_break;
  logic                 tx_done;
  logic [ADDR_BITS-1:0] rx_addr;
  logic                 tmo_hit;

  assign rx_valid = bus.uart_rx_valid;
  assign rx_data  = bus.uart_rx_data;
  assign rx_break = bus.uart_rx_break;
  assign tx_done  = bus.uart_tx_done;
  assign rx_addr  = rx_data[ADDR_BITS-1:0];
  assign tmo_hit  = (tmo_cnt == TIMEOUT_CYCLES - 1);

  assign led = regs[0];

  for (genvar g = 0; g < NREG; g++) begin : g_bus
    assign reg_bus[8*g +: 8] = regs[g];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      op_w             <= 1'b0;
      addr             <= '0;
      tmo_cnt          <= '0;
      bus.uart_tx_en   <= 1'b0;
      bus.uart_tx_data <= 8'h00;
      overrun          <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == 0) ? LED_RESET : 8'h00;
    end else begin
      bus.uart_tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            if (rx_data == CMD_W) begin
              op_w  <= 1'b1;
              state <= GET_ADDR;
            end else if (rx_data == CMD_R) begin
              op_w  <= 1'b0;
              state <= GET_ADDR;
            end else begin
              bus.uart_tx_data <= RSP_ERR;
              state            <= SEND;
            end
          end
        end
        // Break outranks a byte arriving in the same cycle.
        GET_ADDR: begin
          if (rx_break) begin
            state <= IDLE;
          end else if (rx_valid) begin
            addr    <= rx_addr;
            tmo_cnt <= '0;
            if (op_w) begin
              state <= GET_DATA;
            end else begin
              bus.uart_tx_data <= regs[rx_addr];
              state            <= SEND;
            end
          end else if (tmo_hit) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        GET_DATA: begin
          if (rx_break) begin
            state <= IDLE;
          end else if (rx_valid) begin
            regs[addr]       <= rx_data;
            tmo_cnt          <= '0;
            bus.uart_tx_data <= RSP_OK;
            state            <= SEND;
          end else if (tmo_hit) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        SEND: begin
          if (tx_done) begin
            bus.uart_tx_en <= 1'b1;
            state          <= WAIT_BUSY;
          end
        end
        // Wait for the transmitter to drop done, then to finish, before taking a new command.
        WAIT_BUSY: if (!tx_done) state <= WAIT_IDLE;
        WAIT_IDLE: if (tx_done) state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (rx_valid && (state == SEND || state == WAIT_BUSY || state == WAIT_IDLE))
        overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Self-checking bench for uart_cmd_regfile: a transmitter model pops expected
// replies from a scoreboard queue; register/LED state is checked against a local model.
module tb_uart_cmd_regfile;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  led;
  logic [31:0] reg_bus;
  logic        overrun;

  uart_cmd_regfile_if bus ();

  uart_cmd_regfile #(
    .ADDR_BITS      (2),
    .TIMEOUT_CYCLES (TMO),
    .LED_RESET      (8'hF0)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .led     (led),
    .reg_bus (reg_bus),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mreg [4];
  int         tx_cnt = 0;
  int         busy_cnt = 0;
  logic       hold_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_bus();
    return {mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  // Transmitter model: each strobe is checked against the scoreboard, then stays busy a few cycles.
  always @(negedge clk) begin
    if (bus.uart_tx_en) begin
      tx_cnt++;
      if (exp_q.size() == 0)
        chk("spurious_reply_qsize", 32'(exp_q.size()), 32'd1);
      else
        chk("reply_data", {24'h0, bus.uart_tx_data}, {24'h0, exp_q.pop_front()});
      busy_cnt = 6;
    end
    if (busy_cnt > 0) busy_cnt--;
    bus.uart_tx_done = (busy_cnt == 0) && !hold_busy;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = b;
    @(negedge clk);
    bus.uart_rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.uart_tx_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("wait_bound_qsize", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_strobe(input int c0);
    int n = 0;
    while (tx_cnt == c0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("strobe_bound_cnt", 32'(tx_cnt), 32'(c0 + 1));
  endtask

  task automatic model_reset();
    mreg[0] = 8'hF0; mreg[1] = 8'h00; mreg[2] = 8'h00; mreg[3] = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_led"},     {24'h0, led}, 32'h0000_00F0);
    chk({tag, "_reg_bus"}, reg_bus, 32'h0000_00F0);
    chk({tag, "_tx_en"},   {31'h0, bus.uart_tx_en}, 32'h0);
    chk({tag, "_tx_data"}, {24'h0, bus.uart_tx_data}, 32'h0);
    chk({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
  endtask

  initial begin
    int c0;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_break = 1'b0;
    bus.uart_tx_done  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    // Write LED register, with reply latency check
    c0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h00);
    exp_q.push_back(8'h4B);
    send_byte(8'h3C);
    mreg[0] = 8'h3C;
    chk("latency_early_tx_en", {31'h0, bus.uart_tx_en}, 32'h0);
    @(negedge clk);
    chk("latency_tx_en", {31'h0, bus.uart_tx_en}, 32'h1);
    wait_done();
    chk("led_write", {24'h0, led}, 32'h3C);
    chk("w0_strobes", 32'(tx_cnt), 32'(c0 + 1));

    // Address upper bits ignored, then read back
    send_byte(8'h57); send_byte(8'h06); exp_q.push_back(8'h4B); send_byte(8'hA5);
    mreg[2] = 8'hA5;
    wait_done();
    chk("w2_reg_bus", reg_bus, model_bus());
    send_byte(8'h52); exp_q.push_back(8'hA5); send_byte(8'h02);
    wait_done();

    // Unknown command
    c0 = tx_cnt;
    exp_q.push_back(8'h3F); send_byte(8'h41);
    wait_done();
    chk("unknown_strobes", 32'(tx_cnt), 32'(c0 + 1));
    chk("unknown_regs", reg_bus, model_bus());

    // Timeout mid-write
    c0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h01);
    repeat (TMO + 5) @(negedge clk);
    chk("timeout_no_reply", 32'(tx_cnt), 32'(c0));
    send_byte(8'h52); exp_q.push_back(8'h00); send_byte(8'h01);
    wait_done();
    chk("timeout_regs", reg_bus, model_bus());
    chk("pre_overrun", {31'h0, overrun}, 32'h0);

    // Overrun while the transmitter is held busy
    c0 = tx_cnt;
    send_byte(8'h52); exp_q.push_back(8'h3C); send_byte(8'h00);
    wait_strobe(c0);
    hold_busy = 1'b1;
    send_byte(8'h52);
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    repeat (10) @(negedge clk);
    chk("overrun_no_2nd", 32'(tx_cnt), 32'(c0 + 1));
    hold_busy = 1'b0;
    wait_done();
    chk("overrun_idle_no_reply", 32'(tx_cnt), 32'(c0 + 1));
    send_byte(8'h52); exp_q.push_back(8'h3C); send_byte(8'h00);
    wait_done();
    chk("overrun_recover", 32'(tx_cnt), 32'(c0 + 2));
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);

    // Break in GET_ADDR, then break together with valid in GET_DATA
    c0 = tx_cnt;
    send_byte(8'h57);
    @(negedge clk); bus.uart_rx_break = 1'b1;
    @(negedge clk); bus.uart_rx_break = 1'b0;
    send_byte(8'h57); send_byte(8'h03);
    @(negedge clk);
    bus.uart_rx_break = 1'b1; bus.uart_rx_valid = 1'b1; bus.uart_rx_data = 8'h77;
    @(negedge clk);
    bus.uart_rx_break = 1'b0; bus.uart_rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("break_no_reply", 32'(tx_cnt), 32'(c0));
    chk("break_regs", reg_bus, model_bus());
    send_byte(8'h52); exp_q.push_back(8'h00); send_byte(8'h03);
    wait_done();

    // Reset during WAIT_IDLE
    c0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h00); exp_q.push_back(8'h4B); send_byte(8'h11);
    wait_strobe(c0);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_state("midreply_reset");
    repeat (15) @(negedge clk);
    chk("midreply_no_strobe", 32'(tx_cnt), 32'(c0 + 1));
    chk("final_qsize", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
